wb_regfile: RTL and testbench

- Write-back sink of the 5-stage MIPS pipeline; consumes the WB-stage bundle registered out of MEM/WB.
- Holds the 32x32 GPR array and the HI/LO pair.
- Serves two GPR read ports to ID and one HI/LO read port to EX.
- Write-through bypass makes a same-cycle WB write visible to readers, so ID needs no extra WB forwarding path.

---
 rtl/wb_regfile_pkg.sv | 31 +++
 rtl/wb_regfile_hilo_reg.sv | 42 ++++
 rtl/wb_regfile.sv | 86 ++++++++
 tb/tb_wb_regfile.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_regfile_pkg.sv
// Shared widths and read-port source selection for the write-back register file.
package wb_regfile_pkg;

    localparam int REG_BUS_W    = 32;
    localparam int REG_ADDR_W   = 5;
    localparam int REG_NUM      = 32;
    localparam int REG_NUM_LOG2 = 5;

    typedef enum logic [1:0] {
        RD_ZERO   = 2'd0,
        RD_BYPASS = 2'd1,
        RD_ARRAY  = 2'd2
    } rd_sel_t;

    // Read priority: reset, disabled port, $0, same-cycle WB write, stored value.
    function automatic rd_sel_t rd_select(
        input logic rst,
        input logic re,
        input logic addr_is_zero,
        input logic wb_hit
    );
        if (rst || !re || addr_is_zero) begin
            return RD_ZERO;
        end
        if (wb_hit) begin
            return RD_BYPASS;
        end
        return RD_ARRAY;
    endfunction

endpackage

// File: rtl/wb_regfile_hilo_reg.sv
// HI/LO storage with a write-through bypass so EX sees a retiring HI/LO write
// in the same cycle.
module wb_regfile_hilo_reg
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (we_i) begin
            hi_q <= hi_i;
            lo_q <= lo_i;
        end
    end

    always_comb begin
        hi_o = hi_q;
        lo_o = lo_q;
        if (rst) begin
            hi_o = '0;
            lo_o = '0;
        end else if (we_i) begin
            hi_o = hi_i;
            lo_o = lo_i;
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// Write-back sink: 32x32 GPR array with two bypassed read ports, HI/LO pair,
// and a count of committed non-$0 GPR writes.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = REG_BUS_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int NREGS  = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              wb_whilo,
    input  logic [DATA_W-1:0] wb_hi,
    input  logic [DATA_W-1:0] wb_lo,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [31:0]       wr_count
);

    // Entry 0 is only ever reset, so synthesis folds it to a constant.
    logic [DATA_W-1:0] gpr_q [NREGS];
    logic [31:0]       wr_count_q;
    logic [31:0]       wr_count_d;
    logic              gpr_we;
    rd_sel_t           sel1;
    rd_sel_t           sel2;

    assign gpr_we     = wb_wreg && (wb_wd != '0);
    assign wr_count_d = wr_count_q + 32'd1;
    assign wr_count   = wr_count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                gpr_q[i] <= '0;
            end
            wr_count_q <= '0;
        end else if (gpr_we) begin
            gpr_q[wb_wd] <= wb_wdata;
            wr_count_q   <= wr_count_d;
        end
    end

    assign sel1 = rd_select(rst, re1, raddr1 == '0, wb_wreg && (raddr1 == wb_wd));
    assign sel2 = rd_select(rst, re2, raddr2 == '0, wb_wreg && (raddr2 == wb_wd));

    always_comb begin
        rdata1 = '0;
        case (sel1)
            RD_BYPASS: rdata1 = wb_wdata;
            RD_ARRAY:  rdata1 = gpr_q[raddr1];
            default:   rdata1 = '0;
        endcase
    end

    always_comb begin
        rdata2 = '0;
        case (sel2)
            RD_BYPASS: rdata2 = wb_wdata;
            RD_ARRAY:  rdata2 = gpr_q[raddr2];
            default:   rdata2 = '0;
        endcase
    end

    wb_regfile_hilo_reg #(
        .DATA_W(DATA_W)
    ) u_hilo (
        .clk (clk),
        .rst (rst),
        .we_i(wb_whilo),
        .hi_i(wb_hi),
        .lo_i(wb_lo),
        .hi_o(hi_o),
        .lo_o(lo_o)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, write/read, $0, bypass, HI/LO, gating, wrap.
module tb_wb_regfile;

    logic        clk;
    logic        rst;
    logic [4:0]  wb_wd;
    logic        wb_wreg;
    logic [31:0] wb_wdata;
    logic        wb_whilo;
    logic [31:0] wb_hi;
    logic [31:0] wb_lo;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic [31:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;

    wb_regfile dut (
        .clk     (clk),
        .rst     (rst),
        .wb_wd   (wb_wd),
        .wb_wreg (wb_wreg),
        .wb_wdata(wb_wdata),
        .wb_whilo(wb_whilo),
        .wb_hi   (wb_hi),
        .wb_lo   (wb_lo),
        .re1     (re1),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata2  (rdata2),
        .hi_o    (hi_o),
        .lo_o    (lo_o),
        .wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        rst      = 1'b0;
        wb_wd    = '0;
        wb_wreg  = 1'b0;
        wb_wdata = '0;
        wb_whilo = 1'b0;
        wb_hi    = '0;
        wb_lo    = '0;
        re1      = 1'b0;
        raddr1   = '0;
        re2      = 1'b0;
        raddr2   = '0;
    endtask

    // Inputs change 1 ns after the rising edge; outputs are sampled before the next one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gpr_write(input logic [4:0] wd, input logic [31:0] data);
        wb_wd    = wd;
        wb_wreg  = 1'b1;
        wb_wdata = data;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        idle();
        #1;
        check("reset_wr_count", wr_count, 32'd0);
        check("reset_hi", hi_o, 32'd0);
        check("reset_lo", lo_o, 32'd0);

        // Reset clear
        gpr_write(5'd5, 32'h0000_1234);
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        check("pre_rst_r5", rdata1, 32'h0000_1234);
        check("pre_rst_cnt", wr_count, 32'd1);
        rst = 1'b1; wb_whilo = 1'b1; wb_hi = 32'hCAFE_0001; wb_lo = 32'hCAFE_0002;
        #1;
        check("rst_forces_rdata1", rdata1, 32'd0);
        check("rst_forces_hi", hi_o, 32'd0);
        check("rst_forces_lo", lo_o, 32'd0);
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd5;
        #1;
        check("rst_clear_r5", rdata1, 32'd0);
        check("rst_clear_cnt", wr_count, 32'd0);
        check("rst_clear_hi", hi_o, 32'd0);
        check("rst_clear_lo", lo_o, 32'd0);

        // Basic write/read
        idle();
        gpr_write(5'd3, 32'hDEAD_BEEF);
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd3;
        #1;
        check("basic_r3", rdata1, 32'hDEAD_BEEF);
        check("basic_cnt", wr_count, 32'd1);

        // $0 immutability
        idle();
        gpr_write(5'd0, 32'hFFFF_FFFF);
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        check("r0_bypass_blocked", rdata1, 32'd0);
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd0;
        #1;
        check("r0_after", rdata1, 32'd0);
        check("r0_cnt", wr_count, 32'd1);

        // Write-through on both ports
        idle();
        gpr_write(5'd7, 32'h0000_0011);
        tick();
        idle();
        gpr_write(5'd7, 32'h0000_0022);
        re1 = 1'b1; raddr1 = 5'd7;
        re2 = 1'b1; raddr2 = 5'd7;
        #1;
        check("wt_port1", rdata1, 32'h0000_0022);
        check("wt_port2", rdata2, 32'h0000_0022);
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd7;
        re2 = 1'b1; raddr2 = 5'd7;
        #1;
        check("wt_stored1", rdata1, 32'h0000_0022);
        check("wt_stored2", rdata2, 32'h0000_0022);
        check("wt_cnt", wr_count, 32'd3);

        // Address match without wb_wreg must not bypass
        idle();
        wb_wd = 5'd3; wb_wdata = 32'h5555_5555;
        re2 = 1'b1; raddr2 = 5'd3;
        #1;
        check("no_wreg_no_bypass", rdata2, 32'hDEAD_BEEF);

        // HI/LO bypass and hold
        idle();
        wb_whilo = 1'b1; wb_hi = 32'hAAAA_0000; wb_lo = 32'h0000_BBBB;
        #1;
        check("hilo_bypass_hi", hi_o, 32'hAAAA_0000);
        check("hilo_bypass_lo", lo_o, 32'h0000_BBBB);
        tick();
        idle();
        wb_hi = 32'h1357_9BDF; wb_lo = 32'h2468_ACE0;
        #1;
        check("hilo_hold_hi", hi_o, 32'hAAAA_0000);
        check("hilo_hold_lo", lo_o, 32'h0000_BBBB);

        // HI/LO and GPR write in the same cycle
        idle();
        gpr_write(5'd4, 32'h0404_0404);
        wb_whilo = 1'b1; wb_hi = 32'h1111_2222; wb_lo = 32'h3333_4444;
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd4;
        #1;
        check("dual_r4", rdata1, 32'h0404_0404);
        check("dual_hi", hi_o, 32'h1111_2222);
        check("dual_lo", lo_o, 32'h3333_4444);
        check("dual_cnt", wr_count, 32'd4);

        // Read enable gating
        idle();
        re2 = 1'b0; raddr2 = 5'd3;
        re1 = 1'b1; raddr1 = 5'd3;
        #1;
        check("re2_off", rdata2, 32'd0);
        check("re1_on", rdata1, 32'hDEAD_BEEF);

        // Counter wrap via backdoor preload
        idle();
        force dut.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        #1;
        check("wrap_preload", wr_count, 32'hFFFF_FFFF);
        gpr_write(5'd1, 32'h0000_0055);
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd1;
        #1;
        check("wrap_cnt", wr_count, 32'd0);
        check("wrap_r1", rdata1, 32'h0000_0055);

        // Reset coincident with a write drops the write
        idle();
        gpr_write(5'd9, 32'h0000_0099);
        rst = 1'b1;
        tick();
        idle();
        re1 = 1'b1; raddr1 = 5'd9;
        re2 = 1'b1; raddr2 = 5'd7;
        #1;
        check("rst_drop_r9", rdata1, 32'd0);
        check("rst_drop_r7", rdata2, 32'd0);
        check("rst_drop_cnt", wr_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
